// File: rtl/fd_fir_folded.sv
// Folded multi-channel fractional-delay FIR filter.
// One multiply-accumulate unit is shared across all taps, processing one tap
// per cycle. Every channel has its own delay line, and all channels share one
// set of runtime-programmable coefficients. Both the input and output sides
// use valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes allowed
// MAC   | accumulating one tap per cycle for the latched channel
// OUT   | result held on m_* until downstream takes it
module fd_fir_folded #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int NTAPS  = 6,
  parameter int NCH    = 2,
  parameter int ACC_W  = 40,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TAP_W = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_chan,
  input  logic [DATA_W-1:0] s_data,
  input  logic              coef_we,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CH_W-1:0]   m_chan,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sat,
  output logic              err
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] xline [NCH][NTAPS];
  logic signed [COEF_W-1:0] coef  [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [TAP_W-1:0]         tap;
  logic [CH_W-1:0]          chan;

  logic chan_bad, addr_bad;
  logic accept, coef_ok, last_tap;
  logic signed [DATA_W-1:0] x_sel;
  logic signed [COEF_W-1:0] c_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum, acc_half, acc_shr;
  logic                     y_over, y_under;
  logic [DATA_W-1:0]        y;

  // Out-of-range checks only exist when the index width can express them.
  if ((2 ** CH_W) > NCH) begin : g_chan_chk
    assign chan_bad = (s_chan >= CH_W'(NCH));
  end else begin : g_chan_full
    assign chan_bad = 1'b0;
  end

  if ((2 ** TAP_W) > NTAPS) begin : g_addr_chk
    assign addr_bad = (coef_addr >= TAP_W'(NTAPS));
  end else begin : g_addr_full
    assign addr_bad = 1'b0;
  end

  assign s_ready  = (state == IDLE);
  assign accept   = s_ready && s_valid && !chan_bad;
  assign coef_ok  = s_ready && coef_we && !addr_bad;
  assign last_tap = (tap == TAP_W'(NTAPS - 1));

  // Full-precision product, then round half-up and clamp to the sample range.
  assign x_sel    = xline[chan][tap];
  assign c_sel    = coef[tap];
  assign prod     = x_sel * c_sel;
  assign acc_sum  = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_half = acc_sum + HALF;
  assign acc_shr  = acc_half >>> FRAC_W;
  assign y_over   = (acc_shr > Y_MAX);
  assign y_under  = (acc_shr < Y_MIN);
  assign y        = y_over  ? Y_MAX[DATA_W-1:0] :
                    y_under ? Y_MIN[DATA_W-1:0] : acc_shr[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = MAC;
      MAC:     if (last_tap) state_next = OUT;
      OUT:     if (m_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Coefficient bank, written only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (coef_ok) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Per-channel delay lines; only the addressed channel shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++) xline[c][k] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NCH; c++) begin
        if (s_chan == CH_W'(c)) begin
          for (int k = NTAPS - 1; k > 0; k--) xline[c][k] <= xline[c][k-1];
          xline[c][0] <= s_data;
        end
      end
    end
  end

  // Accumulator, tap counter and latched channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tap  <= '0;
      chan <= '0;
    end else if (accept) begin
      acc  <= '0;
      tap  <= '0;
      chan <= s_chan;
    end else if (state == MAC) begin
      acc <= acc_sum;
      tap <= last_tap ? '0 : tap + 1'b1;
    end
  end

  // Output register: loaded on the last tap, held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_chan  <= '0;
      m_data  <= '0;
      m_sat   <= 1'b0;
    end else if (state == MAC && last_tap) begin
      m_valid <= 1'b1;
      m_chan  <= chan;
      m_data  <= y;
      m_sat   <= y_over || y_under;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Error pulse: bad channel consumed, or coefficient write rejected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (s_ready && s_valid && chan_bad) ||
                       (coef_we && (!s_ready || addr_bad));
  end

endmodule
